// File: rtl/axi_lite_ram_port_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite to single-port RAM controller.
package axi_ram_pkg;

    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_EXEC,
        RD_WAIT,
        RD_RESP
    } state_e;

endpackage

// File: rtl/axi_lite_ram_port_ctrl_if.sv
// AXI4-Lite bus bundle between a master and the RAM port controller.
interface axi_lite_ram_port_ctrl_if #(
    parameter int AXI_ADDR_W = 8
);
    logic [AXI_ADDR_W-1:0] s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [31:0]           s_wdata;
    logic [3:0]            s_wstrb;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [AXI_ADDR_W-1:0] s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/axi_lite_ram_port_ctrl.sv
// AXI4-Lite slave driving one port of a registered-output RAM, one access at a time.
// Optional AXI_RAM_ADDR_CHECK_EN: addresses beyond the RAM answer SLVERR without a RAM cycle.
//
// state   | meaning
// IDLE    | ready pulses issued here; handshake latches the request
// WR_EXEC | RAM write cycle (skipped on partial strobes or bad address)
// WR_RESP | bvalid held until bready
// RD_EXEC | RAM read cycle issued
// RD_WAIT | registered RAM output captured into rdata
// RD_RESP | rvalid held until rready
module axi_lite_ram_port_ctrl
    import axi_ram_pkg::*;
#(
    parameter int AXI_ADDR_W = 8,
    parameter int RAM_ADDR_W = 3,
    parameter int RAM_DATA_W = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    axi_lite_ram_port_ctrl_if.slave s_axi,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [RAM_ADDR_W-1:0]   ram_addr,
    output logic [RAM_DATA_W-1:0]   ram_din,
    input  logic [RAM_DATA_W-1:0]   ram_dout
);

    localparam int NLANES = (RAM_DATA_W + 7) / 8;

    state_e                  state_q, state_d;
    logic                    prio_wr_q, prio_wr_d;
    logic                    awready_q, awready_d;
    logic                    arready_q, arready_d;
    logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [RAM_DATA_W-1:0]   din_q, din_d;
    logic                    we_q, we_d;
    logic                    oor_q, oor_d;
    logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;

    logic wr_req, rd_req;
    logic aw_oor, ar_oor;
    logic unused_ok;

    assign wr_req = s_axi.s_awvalid && s_axi.s_wvalid;
    assign rd_req = s_axi.s_arvalid;

`ifdef AXI_RAM_ADDR_CHECK_EN
    assign aw_oor = |(s_axi.s_awaddr >> (RAM_ADDR_W + 2));
    assign ar_oor = |(s_axi.s_araddr >> (RAM_ADDR_W + 2));
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Byte offset, aliased upper address bits and unmapped data lanes are intentionally dropped.
    assign unused_ok = ^{s_axi.s_awaddr, s_axi.s_araddr, s_axi.s_wdata, s_axi.s_wstrb};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            oor_q     <= oor_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        we_d      = we_q;
        oor_d     = oor_q;
        rdata_d   = rdata_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is registered, so the grant is decided one cycle before the handshake.
                if (awready_q) begin
                    if (wr_req) begin
                        addr_d  = s_axi.s_awaddr[RAM_ADDR_W+1:2];
                        din_d   = s_axi.s_wdata[RAM_DATA_W-1:0];
                        we_d    = &s_axi.s_wstrb[NLANES-1:0];
                        oor_d   = aw_oor;
                        state_d = WR_EXEC;
                    end
                end else if (arready_q) begin
                    if (rd_req) begin
                        addr_d  = s_axi.s_araddr[RAM_ADDR_W+1:2];
                        oor_d   = ar_oor;
                        state_d = RD_EXEC;
                    end
                end else if (wr_req && rd_req) begin
                    awready_d = prio_wr_q;
                    arready_d = !prio_wr_q;
                    prio_wr_d = !prio_wr_q;
                end else if (wr_req) begin
                    awready_d = 1'b1;
                end else if (rd_req) begin
                    arready_d = 1'b1;
                end
            end
            WR_EXEC: begin
                ram_en  = !oor_q;
                ram_we  = we_q && !oor_q;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi.s_bready) state_d = IDLE;
            end
            RD_EXEC: begin
                ram_en  = !oor_q;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d = oor_q ? '0 : AXI_DATA_W'(ram_dout);
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi.s_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axi.s_awready = awready_q;
    assign s_axi.s_wready  = awready_q;
    assign s_axi.s_arready = arready_q;
    assign s_axi.s_bvalid  = (state_q == WR_RESP);
    assign s_axi.s_bresp   = (state_q == WR_RESP && oor_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.s_rvalid  = (state_q == RD_RESP);
    assign s_axi.s_rresp   = (state_q == RD_RESP && oor_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.s_rdata   = rdata_q;

    assign ram_addr = addr_q;
    assign ram_din  = din_q;

endmodule

// File: tb/tb_axi_lite_ram_port_ctrl.sv
// Scoreboard bench for axi_lite_ram_port_ctrl with an inline registered-output RAM port.
// Honours AXI_RAM_ADDR_CHECK_EN the same way as the design build.
module tb_axi_lite_ram_port_ctrl;
    import axi_ram_pkg::*;

    localparam int AW = 8;
    localparam int RA = 3;
    localparam int RD = 8;
`ifdef AXI_RAM_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic aclk;
    logic aresetn;
    logic ram_en, ram_we;
    logic [RA-1:0] ram_addr;
    logic [RD-1:0] ram_din, ram_dout;
    logic [RD-1:0] ram_mem [0:7];

    axi_lite_ram_port_ctrl_if #(.AXI_ADDR_W(AW)) bus ();

    axi_lite_ram_port_ctrl #(
        .AXI_ADDR_W(AW), .RAM_ADDR_W(RA), .RAM_DATA_W(RD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .s_axi(bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Port A of the dual-port RAM: write-first not needed, dout is the old word.
    always @(posedge aclk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            ram_dout <= ram_mem[ram_addr];
        end
    end

    rsp_t        exp_rsp [$];
    logic [10:0] exp_w [$];
    logic [7:0]  ref_mem [0:7];
    bit          prio_wr = 1'b1;
    bit          hold_b = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic bit oor_of(input logic [7:0] a);
        return ADDR_CHECK && ((a / 32) != 0);
    endfunction

    function automatic int widx(input logic [7:0] a);
        return (int'(a) / 4) % 8;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        rsp_t r;
        bit o;
        o = oor_of(a);
        if (!o && s[0]) begin
            ref_mem[widx(a)] = d[7:0];
            exp_w.push_back({3'(widx(a)), d[7:0]});
        end
        r.is_rd = 1'b0;
        r.resp  = o ? RESP_SLVERR : RESP_OKAY;
        r.data  = '0;
        exp_rsp.push_back(r);
    endtask

    task automatic model_read(input logic [7:0] a);
        rsp_t r;
        bit o;
        o = oor_of(a);
        r.is_rd = 1'b1;
        r.resp  = o ? RESP_SLVERR : RESP_OKAY;
        r.data  = o ? 32'h0 : {24'h0, ref_mem[widx(a)]};
        exp_rsp.push_back(r);
    endtask

    task automatic drive_txn(input bit do_w, input bit do_r, input logic [7:0] wa,
                             input logic [31:0] wd, input logic [3:0] ws, input logic [7:0] ra);
        bit w_done, r_done, aw_now, ar_now;
        int t;
        w_done = !do_w;
        r_done = !do_r;
        t = 0;
        bus.s_awaddr  = wa;
        bus.s_wdata   = wd;
        bus.s_wstrb   = ws;
        bus.s_araddr  = ra;
        bus.s_awvalid = do_w;
        bus.s_wvalid  = do_w;
        bus.s_arvalid = do_r;
        while (!(w_done && r_done) && t < 300) begin
            @(negedge aclk);
            aw_now = bus.s_awvalid && bus.s_awready && bus.s_wready;
            ar_now = bus.s_arvalid && bus.s_arready;
            @(posedge aclk);
            #1;
            if (aw_now) begin
                bus.s_awvalid = 1'b0;
                bus.s_wvalid  = 1'b0;
                w_done = 1'b1;
            end
            if (ar_now) begin
                bus.s_arvalid = 1'b0;
                r_done = 1'b1;
            end
            t++;
        end
        chk("handshake_timeout", {62'h0, w_done, r_done}, 64'h3);
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        model_write(a, d, s);
        drive_txn(1'b1, 1'b0, a, d, s, 8'h0);
    endtask

    task automatic do_read(input logic [7:0] a);
        model_read(a);
        drive_txn(1'b0, 1'b1, 8'h0, 32'h0, 4'h0, a);
    endtask

    // Simultaneous write and read: the side holding priority goes first, then priority flips.
    task automatic do_both(input logic [7:0] wa, input logic [31:0] d, input logic [3:0] s,
                           input logic [7:0] ra);
        if (prio_wr) begin
            model_write(wa, d, s);
            model_read(ra);
        end else begin
            model_read(ra);
            model_write(wa, d, s);
        end
        prio_wr = !prio_wr;
        drive_txn(1'b1, 1'b1, wa, d, s, ra);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_rsp.size() != 0 && t < 500) begin
            @(posedge aclk);
            #1;
            t++;
        end
        chk("drain_timeout", 64'(exp_rsp.size()), 64'h0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, bus.s_arready,
                 bus.s_rvalid, bus.s_rresp, bus.s_rdata, ram_en, ram_we, ram_addr, ram_din}, 64'h0);
    endtask

    initial begin
        bus.s_bready = 1'b0;
        bus.s_rready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            bus.s_bready = !hold_b && ($urandom_range(0, 2) != 0);
            bus.s_rready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        bit rv_hold, bv_hold, wr_pend, ar_pend, wr_en_exp, wr_we_exp, ar_en_exp;
        logic [31:0] rd_prev;
        int wr_hs, ar_hs;
        rsp_t r;
        logic [10:0] w;
        rv_hold = 0; bv_hold = 0; wr_pend = 0; ar_pend = 0;
        wr_en_exp = 0; wr_we_exp = 0; ar_en_exp = 0;
        rd_prev = '0; wr_hs = -10; ar_hs = -10;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                rv_hold = 0; bv_hold = 0; wr_pend = 0; ar_pend = 0;
                continue;
            end
            if (wr_pend && cyc == wr_hs + 1) begin
                chk("wr_exec_port", {ram_en, ram_we}, {wr_en_exp, wr_we_exp});
                wr_pend = 0;
            end else if (ar_pend && cyc == ar_hs + 1) begin
                chk("rd_exec_port", {ram_en, ram_we}, {ar_en_exp, 1'b0});
                ar_pend = 0;
            end else if (ram_en) begin
                chk("stray_ram_en", ram_en, 0);
            end
            if (ram_en && ram_we) begin
                if (exp_w.size() == 0) chk("unexpected_ram_we", 1, 0);
                else begin
                    w = exp_w.pop_front();
                    chk("ram_write", {ram_addr, ram_din}, w);
                end
            end
            if (bus.s_awvalid && bus.s_awready) begin
                chk("aw_w_together", {bus.s_wready, bus.s_wvalid}, 2'b11);
                wr_hs = cyc;
                wr_pend = 1;
                wr_en_exp = !oor_of(bus.s_awaddr);
                wr_we_exp = wr_en_exp && bus.s_wstrb[0];
            end
            if (bus.s_arvalid && bus.s_arready) begin
                ar_hs = cyc;
                ar_pend = 1;
                ar_en_exp = !oor_of(bus.s_araddr);
            end
            if (bus.s_bvalid || bus.s_rvalid)
                chk("busy_no_ready", {bus.s_awready, bus.s_arready}, 0);
            if (bus.s_bvalid && !bv_hold) chk("b_latency", 64'(cyc - wr_hs), 2);
            if (bus.s_rvalid && !rv_hold) chk("r_latency", 64'(cyc - ar_hs), 3);
            if (bus.s_rvalid && rv_hold) chk("rdata_stable", bus.s_rdata, rd_prev);
            if (bus.s_bvalid && bus.s_bready) begin
                if (exp_rsp.size() == 0) chk("unexpected_b", 1, 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("b_order", r.is_rd, 0);
                    chk("bresp", bus.s_bresp, r.resp);
                end
            end
            if (bus.s_rvalid && bus.s_rready) begin
                if (exp_rsp.size() == 0) chk("unexpected_r", 1, 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("r_order", r.is_rd, 1);
                    chk("rresp", bus.s_rresp, r.resp);
                    chk("rdata", bus.s_rdata, r.data);
                end
            end
            bv_hold = bus.s_bvalid && !bus.s_bready;
            rv_hold = bus.s_rvalid && !bus.s_rready;
            rd_prev = bus.s_rdata;
        end
    end

    initial begin
        logic [7:0] a, ra;
        int kind;
        aresetn = 1'b0;
        bus.s_awaddr = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_araddr = '0;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        #22;
        chk_zero("reset_outputs");
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        for (int i = 0; i < 8; i++) do_write(8'(i * 4), $urandom, 4'hF);
        wait_drain();

        do_write(8'h0C, {$urandom_range(0, 255), 24'h0000A5}, 4'h1);
        do_read(8'h0C);
        wait_drain();

        hold_b = 1'b1;
        do_write(8'h04, 32'h0000_005A, 4'hF);
        fork
            do_read(8'h08);
            begin
                @(negedge aclk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    chk("b_held", {bus.s_bvalid, bus.s_awready, bus.s_arready}, 3'b100);
                end
                hold_b = 1'b0;
            end
        join
        wait_drain();

        do_both(8'h10, 32'h0000_00C3, 4'hF, 8'h10);
        do_both(8'h18, 32'h0000_003C, 4'hF, 8'h14);
        wait_drain();

        do_write(8'h14, 32'h0000_0077, 4'hF);
        do_write(8'h14, 32'h0000_0011, 4'h2);
        do_read(8'h14);
        wait_drain();

        do_read(8'h40);
        do_write(8'hE4, 32'h0000_00EE, 4'hF);
        do_read(8'h04);
        do_read(8'h00);
        wait_drain();

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            a  = 8'($urandom_range(0, 255));
            ra = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[7:5] = 3'b000;
            if ($urandom_range(0, 3) != 0) ra[7:5] = 3'b000;
            case (kind)
                0: do_write(a, $urandom, 4'($urandom_range(0, 15)));
                1: do_read(ra);
                default: do_both(a, $urandom, 4'($urandom_range(0, 15)), ra);
            endcase
        end
        wait_drain();

        do_read(8'h0C);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk_zero("async_reset");
        exp_rsp.delete();
        exp_w.delete();
        prio_wr = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            chk("no_resp_after_reset", {bus.s_bvalid, bus.s_rvalid}, 2'b00);
        end
        @(posedge aclk);
        #1;
        do_read(8'h0C);
        wait_drain();

        chk("rsp_queue_empty", 64'(exp_rsp.size()), 0);
        chk("ram_write_queue_empty", 64'(exp_w.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram_port_ctrl.md
Name: axi_lite_ram_port_ctrl

Overview:
AXI4-Lite slave that turns register-style bus accesses into single-port RAM cycles. It drives one port (en/we/addr/din, registered dout) of the team's 8x8 true dual-port RAM and is the initiator on that port. The other RAM port stays free for a second master. One access is in flight at a time. Reads account for the RAM's one-cycle registered output.

Parameters:
AXI_ADDR_W, 8, AXI byte-address width
RAM_ADDR_W, 3, RAM word-address width (RAM depth = 2**RAM_ADDR_W)
RAM_DATA_W, 8, RAM word width (<=32), mapped to AXI byte lane(s) starting at bit 0

Ports:
aclk  in  1  single clock for bus and RAM port
aresetn  in  1  asynchronous active-low reset
s_awaddr  in  AXI_ADDR_W  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AXI_ADDR_W  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
ram_en  out  1  RAM port enable
ram_we  out  1  RAM port write enable
ram_addr  out  RAM_ADDR_W  RAM word address
ram_din  out  RAM_DATA_W  RAM write data
ram_dout  in  RAM_DATA_W  RAM registered read data

Behaviour:
- Reset: async assert, sync deassert. All outputs are 0. FSM goes to IDLE. Priority bit = write.
- Word index = addr[RAM_ADDR_W+1:2]. addr[1:0] is ignored.
- FSM states: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
- IDLE, write request (awvalid&&wvalid): awready and wready pulse together for one cycle. Address, data and strobes are latched. Go to WR_EXEC. AW and W are never accepted separately; a lone AW or lone W waits.
- IDLE, read request (arvalid): arready pulses one cycle. Address is latched. Go to RD_EXEC.
- IDLE, both requests in the same cycle: round-robin. The granted side loses priority next time.
- WR_EXEC: one cycle.
  - ram_en=1; ram_we = &wstrb[lanes covered by RAM_DATA_W]; ram_din = wdata[RAM_DATA_W-1:0].
  - Partial strobes: no RAM write (ram_we=0), response is still OKAY.
  - Go to WR_RESP.
- WR_RESP: bvalid=1, bresp=OKAY. Held until bready. Go to IDLE the cycle after the handshake.
- RD_EXEC: ram_en=1, ram_we=0, one cycle. Go to RD_WAIT.
- RD_WAIT: capture rdata = zero-extended ram_dout. Go to RD_RESP.
- RD_RESP: rvalid=1, rresp=OKAY. rdata stays stable until rready. Then go to IDLE.
- ram_en/ram_we are 0 in every state except the EXEC states.
- Latency, ready-to-valid:
  - Write: AW/W handshake cycle N, RAM write at N+1, bvalid at N+2.
  - Read: AR handshake N, ram_en N+1, capture N+2, rvalid N+3.
- Back-to-back: minimum one IDLE cycle between transactions.
- Reset mid-transaction: the transaction is dropped and no response is issued. A RAM write already clocked at WR_EXEC persists.

Optional Feature:
AXI_RAM_ADDR_CHECK_EN
- Defined: any nonzero address bit above RAM_ADDR_W+1 is out of range.
  - Write: WR_EXEC drives ram_en=0, bresp=SLVERR.
  - Read: RD_EXEC drives ram_en=0, rdata=0, rresp=SLVERR.
  - Response timing is unchanged.
- Undefined: upper bits are ignored, the address aliases (wraps), and the response is always OKAY.

Decomposition:
- Package axi_ram_pkg holds:
  - state enum typedef;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - AXI data width localparam 32.
- No sub-module. A single FSM module is natural. The bench instantiates it together with true_dual_port_ram port A.

Test Plan:
- Write 0xA5 to addr 0x0C (word 3) with wstrb=4'h1 -> ram_we high one cycle with addr 3 / din 0xA5; bvalid 2 cycles after handshake, bresp=0. Read 0x0C -> rvalid 3 cycles after arready, rdata=0x000000A5.
- AW and W valid with bready=0 for 5 cycles -> bvalid held high, no new awready/arready until the B handshake.
- awvalid+wvalid+arvalid in the same IDLE cycle, twice in a row -> first grant write, second grant read (round-robin).
- wstrb=4'h2 write of 0x11 to word 5 (pre-filled 0x77) -> no ram_we, bresp OKAY, read-back 0x77.
- aresetn low during RD_WAIT -> all outputs 0 asynchronously; after release no rvalid; next read completes normally.
- AXI_RAM_ADDR_CHECK_EN defined, read addr 0x40 -> ram_en never asserted, rresp=SLVERR, rdata=0. Undefined -> aliases to word 0 with OKAY.
